// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: one instruction in flight, owns the PC, the BL
// link write and the retired-instruction counter.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DEC_WINDOW   = 4,
    parameter int          EXEC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        decode_en,
    input  logic        dec_branch_en,
    input  logic        dec_branch_cond,
    input  logic        dec_branch_link,
    input  logic [23:0] dec_branch_offset,
    input  logic        dec_alu_en,
    input  logic        dec_sdt_en,
    input  logic        exec_done,
    input  logic        pc_wr_en,
    input  logic [31:0] pc_wr_value,
    output logic [31:0] pc,
    output logic        lr_we,
    output logic [31:0] lr_wdata,
    output logic [31:0] instret,
    output logic        idle,
    output logic        fault,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_DWAIT  = 3'd3,
        S_EXEC   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int WW = $clog2(DEC_WINDOW) + 1;
    localparam int TW = $clog2(EXEC_TIMEOUT) + 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(DEC_WINDOW - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(EXEC_TIMEOUT - 1);

    state_t        state;
    logic [WW-1:0] win_cnt;
    logic [TW-1:0] to_cnt;

    logic [31:0] pc_seq;
    logic [31:0] branch_target;
    logic        retire;
    logic [31:0] next_pc;

    assign pc_seq        = pc + 32'd4;
    // ARM branch: PC reads as current+8, offset is a signed word count.
    assign branch_target = pc + 32'd8 + {{6{dec_branch_offset[23]}}, dec_branch_offset, 2'b00};
    assign state_dbg     = state;

    // Retirement decision and the PC it commits; priority follows the DWAIT order.
    always_comb begin
        retire  = 1'b0;
        next_pc = pc;
        case (state)
            S_DWAIT: begin
                if (dec_branch_en) begin
                    retire  = 1'b1;
                    next_pc = dec_branch_cond ? branch_target : pc_seq;
                end else if (!(dec_alu_en || dec_sdt_en) && (win_cnt == WIN_LAST)) begin
                    retire  = 1'b1;
                    next_pc = pc_seq;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    retire  = 1'b1;
                    next_pc = pc_wr_en ? pc_wr_value : pc_seq;
                end
            end
            default: begin
                retire  = 1'b0;
                next_pc = pc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            mem_addr  <= RESET_PC;
            mem_req   <= 1'b0;
            instr     <= 32'd0;
            decode_en <= 1'b0;
            lr_we     <= 1'b0;
            lr_wdata  <= 32'd0;
            instret   <= 32'd0;
            idle      <= 1'b1;
            fault     <= 1'b0;
            win_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            decode_en <= 1'b0;
            lr_we     <= 1'b0;

            if (retire) begin
                pc       <= next_pc;
                mem_addr <= next_pc;
                instret  <= instret + 32'd1;
                if (state == S_DWAIT && dec_branch_en && dec_branch_cond && dec_branch_link) begin
                    lr_we    <= 1'b1;
                    lr_wdata <= pc_seq;
                end
                if (run) begin
                    state   <= S_FETCH;
                    mem_req <= 1'b1;
                end else begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            state    <= S_FETCH;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            idle     <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        if (mem_ready) begin
                            instr     <= mem_rdata;
                            mem_req   <= 1'b0;
                            decode_en <= 1'b1;
                            state     <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        win_cnt <= '0;
                        state   <= S_DWAIT;
                    end
                    S_DWAIT: begin
                        if (dec_alu_en || dec_sdt_en) begin
                            to_cnt <= '0;
                            state  <= S_EXEC;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    S_EXEC: begin
                        if (to_cnt == TO_LAST) begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    S_FAULT: begin
                        state <= S_FAULT;
                    end
                    default: begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: inputs change and outputs are checked at
// the falling edge; every expectation is a hand-computed constant.
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        decode_en;
    logic        dec_branch_en;
    logic        dec_branch_cond;
    logic        dec_branch_link;
    logic [23:0] dec_branch_offset;
    logic        dec_alu_en;
    logic        dec_sdt_en;
    logic        exec_done;
    logic        pc_wr_en;
    logic [31:0] pc_wr_value;
    logic [31:0] pc;
    logic        lr_we;
    logic [31:0] lr_wdata;
    logic [31:0] instret;
    logic        idle;
    logic        fault;
    logic [2:0]  state_dbg;

    int n_cmp;
    int n_fail;

    instr_sequencer #(
        .RESET_PC     (32'h0000_0100),
        .DEC_WINDOW   (4),
        .EXEC_TIMEOUT (64)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .run               (run),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
        .instr             (instr),
        .decode_en         (decode_en),
        .dec_branch_en     (dec_branch_en),
        .dec_branch_cond   (dec_branch_cond),
        .dec_branch_link   (dec_branch_link),
        .dec_branch_offset (dec_branch_offset),
        .dec_alu_en        (dec_alu_en),
        .dec_sdt_en        (dec_sdt_en),
        .exec_done         (exec_done),
        .pc_wr_en          (pc_wr_en),
        .pc_wr_value       (pc_wr_value),
        .pc                (pc),
        .lr_we             (lr_we),
        .lr_wdata          (lr_wdata),
        .instret           (instret),
        .idle              (idle),
        .fault             (fault),
        .state_dbg         (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a word with zero-wait fetch; returns in the middle of the third DWAIT cycle.
    task automatic do_fetch(input logic [31:0] w, input string tag);
        mem_ready = 1'b1;
        mem_rdata = w;
        tick();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        chk({tag, "_decode_en"}, decode_en, 1'b1);
        chk({tag, "_instr"}, instr, w);
        chk({tag, "_req_low"}, mem_req, 1'b0);
        tick();
        chk({tag, "_decode_en_once"}, decode_en, 1'b0);
        tick();
        chk({tag, "_no_decode_c3"}, decode_en, 1'b0);
        tick();
    endtask

    task automatic clear_dec();
        dec_branch_en     = 1'b0;
        dec_branch_cond   = 1'b0;
        dec_branch_link   = 1'b0;
        dec_branch_offset = 24'd0;
        dec_alu_en        = 1'b0;
        dec_sdt_en        = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        run         = 1'b0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'd0;
        exec_done   = 1'b0;
        pc_wr_en    = 1'b0;
        pc_wr_value = 32'd0;
        clear_dec();
        tick();
        tick();

        // reset values
        chk("rst_pc", pc, 32'h100);
        chk("rst_mem_addr", mem_addr, 32'h100);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_fault", fault, 1'b0);
        chk("rst_lr_we", lr_we, 1'b0);
        chk("rst_lr_wdata", lr_wdata, 32'd0);
        chk("rst_decode_en", decode_en, 1'b0);

        rst = 1'b0;
        run = 1'b1;
        tick();
        chk("start_req", mem_req, 1'b1);
        chk("start_addr", mem_addr, 32'h100);
        chk("start_idle", idle, 1'b0);

        // BL +2 at 0x100 -> target 0x110, link 0x104
        do_fetch(32'hEB00_0002, "bl");
        dec_branch_en     = 1'b1;
        dec_branch_cond   = 1'b1;
        dec_branch_link   = 1'b1;
        dec_branch_offset = 24'd2;
        tick();
        clear_dec();
        chk("bl_lr_we", lr_we, 1'b1);
        chk("bl_lr_wdata", lr_wdata, 32'h104);
        chk("bl_addr", mem_addr, 32'h110);
        chk("bl_req", mem_req, 1'b1);
        chk("bl_instret", instret, 32'd1);
        tick();
        chk("bl_lr_we_once", lr_we, 1'b0);
        chk("stall_req", mem_req, 1'b1);
        chk("stall_addr", mem_addr, 32'h110);

        // BEQ not taken at 0x110, link ignored
        do_fetch(32'h0A00_0004, "beq");
        dec_branch_en     = 1'b1;
        dec_branch_cond   = 1'b0;
        dec_branch_link   = 1'b1;
        dec_branch_offset = 24'd4;
        tick();
        clear_dec();
        chk("beq_lr_we", lr_we, 1'b0);
        chk("beq_addr", mem_addr, 32'h114);
        chk("beq_pc", pc, 32'h114);
        chk("beq_instret", instret, 32'd2);

        // condition-failed skip at 0x114: retire at the end of the fourth DWAIT cycle
        do_fetch(32'hE1A0_0000, "skip");
        tick();
        chk("skip_not_early", mem_req, 1'b0);
        chk("skip_no_redecode", decode_en, 1'b0);
        chk("skip_instret_hold", instret, 32'd2);
        tick();
        chk("skip_req", mem_req, 1'b1);
        chk("skip_addr", mem_addr, 32'h118);
        chk("skip_instret", instret, 32'd3);

        // ALU at 0x118, exec_done after 3 EXEC cycles with PC write 0x2000
        do_fetch(32'hE080_0001, "alu");
        dec_alu_en = 1'b1;
        tick();
        clear_dec();
        chk("alu_exec_state", state_dbg, 3'd4);
        tick();
        tick();
        exec_done   = 1'b1;
        pc_wr_en    = 1'b1;
        pc_wr_value = 32'h2000;
        chk("alu_wait_req", mem_req, 1'b0);
        tick();
        exec_done = 1'b0;
        pc_wr_en  = 1'b0;
        chk("alu_addr", mem_addr, 32'h2000);
        chk("alu_req", mem_req, 1'b1);
        chk("alu_instret", instret, 32'd4);

        // backward branch (-2 words) with ALU also high: branch wins, target = pc
        do_fetch(32'hEAFF_FFFE, "bneg");
        dec_branch_en     = 1'b1;
        dec_branch_cond   = 1'b1;
        dec_branch_offset = 24'hFF_FFFE;
        dec_alu_en        = 1'b1;
        tick();
        clear_dec();
        chk("bneg_addr", mem_addr, 32'h2000);
        chk("bneg_req", mem_req, 1'b1);
        chk("bneg_lr_we", lr_we, 1'b0);
        chk("bneg_instret", instret, 32'd5);

        // SDT, run dropped during EXEC, exec_done without PC write -> IDLE
        do_fetch(32'hE591_0000, "sdt");
        dec_sdt_en = 1'b1;
        tick();
        clear_dec();
        run = 1'b0;
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("park_idle", idle, 1'b1);
        chk("park_req", mem_req, 1'b0);
        chk("park_pc", pc, 32'h2004);
        chk("park_instret", instret, 32'd6);
        tick();
        chk("park_stays", mem_req, 1'b0);
        run = 1'b1;
        tick();
        chk("resume_req", mem_req, 1'b1);
        chk("resume_addr", mem_addr, 32'h2004);

        // enables outside DWAIT are ignored
        dec_branch_en   = 1'b1;
        dec_branch_cond = 1'b1;
        tick();
        clear_dec();
        chk("ign_pc", pc, 32'h2004);
        chk("ign_instret", instret, 32'd6);
        chk("ign_req", mem_req, 1'b1);

        // async reset in the middle of a stalled fetch
        rst = 1'b1;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_pc", pc, 32'h100);
        chk("arst_addr", mem_addr, 32'h100);
        tick();
        chk("arst_instret", instret, 32'd0);
        chk("arst_idle", idle, 1'b1);
        rst = 1'b0;
        tick();
        chk("refetch_req", mem_req, 1'b1);
        chk("refetch_addr", mem_addr, 32'h100);

        // SDT with no exec_done: fault exactly after 64 EXEC cycles
        do_fetch(32'hE581_0000, "to");
        dec_sdt_en = 1'b1;
        tick();
        clear_dec();
        for (int i = 0; i < 63; i++) tick();
        chk("to_not_early", fault, 1'b0);
        tick();
        chk("to_fault", fault, 1'b1);
        chk("to_req", mem_req, 1'b0);
        tick();
        tick();
        tick();
        chk("fault_sticky", fault, 1'b1);
        chk("fault_no_req", mem_req, 1'b0);
        chk("fault_pc", pc, 32'h100);
        chk("fault_idle", idle, 1'b0);
        chk("fault_instret", instret, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
